ram_bist_ctrl: RTL
==================

# ram_bist_ctrl

Built-in self-test sequencer for the 1024 x 32 single-port block RAM. It sits directly upstream of the RAM and drives its write-enable, read-enable, address and write-data ports. It consumes the registered read data one cycle later. On `start` it writes a seeded pattern to every location, reads every location back, compares each word and reports pass/fail, an error count and the first failing address and data.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM address width. Depth is DEPTH = 2^ADDR_W.
- `DATA_W`, default 32: RAM data width. Must be at least ADDR_W.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to run a test. Accepted only when not busy.
- `seed`  in  DATA_W: pattern seed, latched when `start` is accepted.
- `ram_wr_en`  out  1: RAM write enable.
- `ram_rd_en`  out  1: RAM read enable.
- `ram_addr`  out  ADDR_W: RAM address.
- `ram_wdata`  out  DATA_W: RAM write data.
- `ram_rdata`  in  DATA_W: RAM read data, valid the cycle after `ram_rd_en`.
- `busy`  out  1: test in progress.
- `done`  out  1: test complete. Held high until the next accepted `start` or `rst`.
- `pass`  out  1: test complete with zero mismatches. Qualified by `done`.
- `err_count`  out  ADDR_W+1: number of mismatching words.
- `first_err_addr`  out  ADDR_W: address of the first mismatch.
- `first_err_data`  out  DATA_W: data read at the first mismatch.

## Operation
- Pattern: expected(a) = seed_q XOR zero-extended a. seed_q is the latched seed.
- FSM states and transitions:
  - IDLE -> WRITE when `start`=1.
  - WRITE -> READ after address DEPTH-1 is written.
  - READ -> DRAIN after address DEPTH-1 is read.
  - DRAIN -> DONE after one cycle.
  - DONE -> WRITE when `start`=1.
- WRITE: `ram_wr_en`=1, `ram_rd_en`=0. Address increments 0..DEPTH-1, one word per cycle. `ram_wdata` = expected(`ram_addr`).
- READ: `ram_rd_en`=1, `ram_wr_en`=0. Address increments 0..DEPTH-1.
  - A one-stage delay line carries (valid, addr) alongside each read.
  - The compare happens the cycle the data returns, against expected(delayed addr).
- DRAIN: no RAM enables. Compares the final returned word.
- On mismatch: `err_count` increments. It cannot overflow, because the maximum is DEPTH.
- On the first mismatch of a run only: `first_err_addr` and `first_err_data` are captured.
- Accepting `start` clears `done`, `pass`, `err_count`, `first_err_addr` and `first_err_data`, and latches `seed`.
- `start` while `busy`=1 is ignored. It has no effect on the run or the seed.
- `ram_wr_en` and `ram_rd_en` are never high in the same cycle.
- Address wrap: the address counter is ADDR_W bits wide. Phase end is detected at DEPTH-1, not at rollover.
- Reset mid-run: the FSM returns to IDLE and all outputs take their reset values. RAM contents are not touched. The next `start` runs a full fresh test.
- Reset values: all outputs are 0. This covers `ram_wr_en`, `ram_rd_en`, `ram_addr`, `ram_wdata`, `busy`, `done`, `pass`, `err_count`, `first_err_addr` and `first_err_data`.

## Timing
- All outputs are registered.
- Let E0 be the rising edge that samples `start`=1.
  - Cycle after E0: `busy`=1, `ram_wr_en`=1, `ram_addr`=0.
  - Write phase occupies cycles 1..DEPTH after E0.
  - Read phase occupies cycles DEPTH+1..2·DEPTH.
  - DRAIN occupies cycle 2·DEPTH+1.
  - `done`=1 and `busy`=0 from cycle 2·DEPTH+2.
  - For the default DEPTH=1024, `done` rises 2050 cycles after E0.
- Read latency assumed from the RAM: exactly 1 cycle (rd_en at edge n, data valid after edge n+1).
- `pass`, `err_count` and the first-error fields are final in the same cycle `done` rises.
- A back-to-back `start` in the first DONE cycle is accepted. `done` drops in the next cycle.

## Test plan
- Clean RAM model, seed=0x00000000:
  - `done` at E0+2050, `pass`=1, `err_count`=0.
  - The bench checks all 1024 writes with wdata=addr.
- Clean RAM, seed=0xA5A5A5A5:
  - Location 0x3FF holds 0xA5A5A65A, `pass`=1.
  - Rerun immediately from DONE with seed=0xFFFFFFFF: `pass`=1, location 5 holds 0xFFFFFFFA.
- RAM model forces bit 7 stuck-at-1 at addresses 0x010 and 0x200, seed=0:
  - `pass`=0, `err_count`=2.
  - `first_err_addr`=0x010, `first_err_data`=0x00000090.
- RAM model forces every read to 0, seed=0:
  - `err_count`=1023 (address 0 matches).
  - `first_err_addr`=0x001, `first_err_data`=0.
- Pulse `start` at cycle 500 of a run: ignored, with no change to timing or results. Then assert `rst` at cycle 1500:
  - The next cycle shows all outputs 0.
  - A new `start` completes with `pass`=1 2050 cycles later.
- Protocol check throughout: `ram_wr_en`&`ram_rd_en` is never 1, and `busy`&`done` is never 1.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
// -----------------------------------------------------------------------------
// Built-in self-test sequencer for a single-port block RAM with a registered
// read port. On an accepted `start` it writes expected(a) = seed ^ a to every
// location, reads every location back, and compares each returned word. At the
// end it reports pass/fail, the mismatch count and the first failing address
// and data.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   start          in   one-cycle run request, ignored while busy
//   seed           in   [DATA_W]  pattern seed, latched when start is accepted
//   ram_wr_en      out  RAM write enable
//   ram_rd_en      out  RAM read enable
//   ram_addr       out  [ADDR_W] RAM address
//   ram_wdata      out  [DATA_W] RAM write data
//   ram_rdata      in   [DATA_W] RAM read data, valid the cycle after ram_rd_en
//   busy           out  test in progress
//   done           out  test complete, held until next accepted start or rst
//   pass           out  zero mismatches, qualified by done
//   err_count      out  [ADDR_W+1] number of mismatching words
//   first_err_addr out  [ADDR_W] address of the first mismatch
//   first_err_data out  [DATA_W] data read at the first mismatch
// -----------------------------------------------------------------------------
module ram_bist_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    // Phase end is detected at the last address, never at counter rollover.
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] seed_q, seed_n;

    // One-stage delay line that travels with each read so the compare lines up
    // with the RAM's registered read data.
    logic              rd_valid_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic              wr_en_n, rd_en_n, busy_n, done_n, pass_n;
    logic [ADDR_W-1:0] addr_n, first_err_addr_n;
    logic [DATA_W-1:0] wdata_n, first_err_data_n;
    logic [ADDR_W:0]   err_count_n;
    logic              mismatch;

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_n          = state;
        seed_n           = seed_q;
        addr_n           = ram_addr;
        wr_en_n          = 1'b0;
        rd_en_n          = 1'b0;
        wdata_n          = '0;
        busy_n           = busy;
        done_n           = done;
        pass_n           = pass;
        err_count_n      = err_count;
        first_err_addr_n = first_err_addr;
        first_err_data_n = first_err_data;

        // Compare the word returning this cycle against the pattern for the
        // address that was read one cycle earlier.
        mismatch = rd_valid_q && (ram_rdata != (seed_q ^ DATA_W'(rd_addr_q)));
        if (mismatch) begin
            err_count_n = err_count + 1'b1;
            if (err_count == '0) begin
                first_err_addr_n = rd_addr_q;
                first_err_data_n = ram_rdata;
            end
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n          = S_WRITE;
                    seed_n           = seed;
                    addr_n           = '0;
                    wr_en_n          = 1'b1;
                    wdata_n          = seed;  // expected(0) = seed
                    busy_n           = 1'b1;
                    done_n           = 1'b0;
                    pass_n           = 1'b0;
                    err_count_n      = '0;
                    first_err_addr_n = '0;
                    first_err_data_n = '0;
                end
            end
            S_WRITE: begin
                if (ram_addr == ADDR_LAST) begin
                    state_n = S_READ;
                    addr_n  = '0;
                    rd_en_n = 1'b1;
                end else begin
                    addr_n  = ram_addr + 1'b1;
                    wr_en_n = 1'b1;
                    wdata_n = seed_q ^ DATA_W'(addr_n);
                end
            end
            S_READ: begin
                if (ram_addr == ADDR_LAST) begin
                    state_n = S_DRAIN;
                    addr_n  = '0;
                end else begin
                    addr_n  = ram_addr + 1'b1;
                    rd_en_n = 1'b1;
                end
            end
            S_DRAIN: begin
                // The final word is compared this cycle, so the verdict uses
                // the updated count.
                state_n = S_DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                pass_n  = (err_count_n == '0);
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay line is reset along with the controller so no
            // stale read is compared after reset; the RAM itself is left alone.
            state          <= S_IDLE;
            seed_q         <= '0;
            rd_valid_q     <= 1'b0;
            rd_addr_q      <= '0;
            ram_wr_en      <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else begin
            state          <= state_n;
            seed_q         <= seed_n;
            rd_valid_q     <= ram_rd_en;
            rd_addr_q      <= ram_addr;
            ram_wr_en      <= wr_en_n;
            ram_rd_en      <= rd_en_n;
            ram_addr       <= addr_n;
            ram_wdata      <= wdata_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_count_n;
            first_err_addr <= first_err_addr_n;
            first_err_data <= first_err_data_n;
        end
    end

endmodule
